// File: rtl/intdiv_seq.sv
// Iterative signed divider: one non-restoring SD2 row per clock, then one
// adjustment cycle that yields a truncating quotient and a remainder with the sign of x.
module intdiv_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic [N-1:0] r,
  output logic         dbz,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE and out_valid only in DONE, so they are never
  // both high and no operand is accepted on the edge that hands off a result.
  // The DONE outputs stay stable until out_ready is seen.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE = N'(1);

  state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [N-1:0]   xr, yr;
  logic [N:0]     pr;
  logic [2*N-1:0] qd;

  logic       is_ovf;
  logic [N:0] ys, pr_sh, pr_row;
  logic       row_pos;

  logic [N-1:0] qp, qn, q_raw, z_adj, r_adj;

  assign is_ovf    = (x == MIN) && (&y);
  assign dbg_state = state;

  // A row subtracts y when the partial remainder and y share a sign, else adds it.
  assign ys      = {yr[N-1], yr};
  assign pr_sh   = {pr[N-1:0], xr[cnt]};
  assign row_pos = (pr[N] == yr[N-1]);
  assign pr_row  = row_pos ? (pr_sh - ys) : (pr_sh + ys);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ((y == '0) || is_ovf) ? DONE : ITER;
      end
      ITER: if (cnt == '0) state_nxt = ADJ;
      ADJ:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit 01/10 is +1 and 11 is -1, so the quotient is (plus bits) - (minus bits).
  // An exact multiple leaves pr at +-y; otherwise a remainder of the wrong sign
  // is pulled back by one multiple of y.
  always_comb begin
    qp = '0;
    qn = '0;
    for (int i = 0; i < N; i++) begin
      qp[i] = qd[2*i+1] ^ qd[2*i];
      qn[i] = qd[2*i+1] & qd[2*i];
    end
    q_raw = qp - qn;
    z_adj = q_raw;
    r_adj = pr[N-1:0];
    if (pr == ys) begin
      z_adj = q_raw + ONE;
      r_adj = '0;
    end else if (pr == -ys) begin
      z_adj = q_raw - ONE;
      r_adj = '0;
    end else if ((pr != '0) && (pr[N] != xr[N-1])) begin
      if (pr[N] == yr[N-1]) begin
        z_adj = q_raw + ONE;
        r_adj = pr[N-1:0] - yr;
      end else begin
        z_adj = q_raw - ONE;
        r_adj = pr[N-1:0] + yr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      xr  <= '0;
      yr  <= '0;
      pr  <= '0;
      qd  <= '0;
      z   <= '0;
      r   <= '0;
      dbz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr <= x;
            yr <= y;
            if (y == '0) begin
              z   <= '1;
              r   <= x;
              dbz <= 1'b1;
              ovf <= 1'b0;
            end else if (is_ovf) begin
              z   <= MIN;
              r   <= '0;
              dbz <= 1'b0;
              ovf <= 1'b1;
            end else begin
              cnt <= CW'(N-1);
              pr  <= {(N+1){x[N-1]}};
              qd  <= '0;
            end
          end
        end
        ITER: begin
          pr <= pr_row;
          qd[2*cnt +: 2] <= row_pos ? 2'b01 : 2'b11;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        ADJ: begin
          z   <= z_adj;
          r   <= r_adj;
          dbz <= 1'b0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed bench for intdiv_seq (N=4): arithmetic, special cases, latency,
// backpressure and asynchronous reset abort.
module tb_intdiv_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] z;
  logic [N-1:0] r;
  logic         dbz;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  intdiv_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .r(r), .dbz(dbz), .ovf(ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Present one operand pair, return edges from the accepting edge until
  // out_valid is seen (0 means the accepting edge itself registered the result).
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      output int edges, output int acc_cyc);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    x = a;
    y = b;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (z !== 4'b0000 || r !== 4'b0000) begin n_err++; $display("FAIL rst_zr: got z=%b r=%b want 0000/0000", z, r); end
    n_cmp++; if (dbz !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL rst_flags: got dbz=%b ovf=%b want 0/0", dbz, ovf); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int e, a;
    send(4'b0111, 4'b0010, e, a);
    n_cmp++; if (e !== 5) begin n_err++; $display("FAIL lat_7_2: got %0d edges want 5", e); end
    n_cmp++; if (z !== 4'b0011 || r !== 4'b0001) begin n_err++; $display("FAIL div_7_2: got z=%b r=%b want 0011/0001", z, r); end
    n_cmp++; if (dbz !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL flags_7_2: got dbz=%b ovf=%b want 0/0", dbz, ovf); end
  endtask

  task automatic test_signs();
    int e, a;
    send(4'b1001, 4'b0010, e, a);
    n_cmp++; if (z !== 4'b1101 || r !== 4'b1111) begin n_err++; $display("FAIL div_m7_2: got z=%b r=%b want 1101/1111", z, r); end
    send(4'b0111, 4'b1110, e, a);
    n_cmp++; if (z !== 4'b1101 || r !== 4'b0001) begin n_err++; $display("FAIL div_7_m2: got z=%b r=%b want 1101/0001", z, r); end
    send(4'b1000, 4'b0011, e, a);
    n_cmp++; if (z !== 4'b1110 || r !== 4'b1110) begin n_err++; $display("FAIL div_m8_3: got z=%b r=%b want 1110/1110", z, r); end
    send(4'b1001, 4'b1101, e, a);
    n_cmp++; if (z !== 4'b0010 || r !== 4'b1111) begin n_err++; $display("FAIL div_m7_m3: got z=%b r=%b want 0010/1111", z, r); end
  endtask

  task automatic test_exact();
    int e, a;
    send(4'b1010, 4'b0011, e, a);
    n_cmp++; if (z !== 4'b1110 || r !== 4'b0000) begin n_err++; $display("FAIL div_m6_3: got z=%b r=%b want 1110/0000", z, r); end
    send(4'b0000, 4'b0101, e, a);
    n_cmp++; if (z !== 4'b0000 || r !== 4'b0000) begin n_err++; $display("FAIL div_0_5: got z=%b r=%b want 0000/0000", z, r); end
    send(4'b0110, 4'b1101, e, a);
    n_cmp++; if (z !== 4'b1110 || r !== 4'b0000) begin n_err++; $display("FAIL div_6_m3: got z=%b r=%b want 1110/0000", z, r); end
    send(4'b1000, 4'b1000, e, a);
    n_cmp++; if (z !== 4'b0001 || r !== 4'b0000) begin n_err++; $display("FAIL div_m8_m8: got z=%b r=%b want 0001/0000", z, r); end
  endtask

  task automatic test_special();
    int e, a;
    send(4'b1000, 4'b1111, e, a);
    n_cmp++; if (e !== 0) begin n_err++; $display("FAIL lat_ovf: got %0d extra edges want 0", e); end
    n_cmp++; if (z !== 4'b1000 || r !== 4'b0000) begin n_err++; $display("FAIL ovf_zr: got z=%b r=%b want 1000/0000", z, r); end
    n_cmp++; if (ovf !== 1'b1 || dbz !== 1'b0) begin n_err++; $display("FAIL ovf_flags: got ovf=%b dbz=%b want 1/0", ovf, dbz); end
    send(4'b0101, 4'b0000, e, a);
    n_cmp++; if (e !== 0) begin n_err++; $display("FAIL lat_dbz: got %0d extra edges want 0", e); end
    n_cmp++; if (z !== 4'b1111 || r !== 4'b0101) begin n_err++; $display("FAIL dbz_zr: got z=%b r=%b want 1111/0101", z, r); end
    n_cmp++; if (dbz !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL dbz_flags: got dbz=%b ovf=%b want 1/0", dbz, ovf); end
  endtask

  task automatic test_backpressure();
    int e, a;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0111, 4'b1110, e, a);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      x = 4'(i + 3);
      y = 4'(i + 1);
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (z !== 4'b1101 || r !== 4'b0001) begin n_err++; $display("FAIL bp_zr[%0d]: got z=%b r=%b want 1101/0001", i, z, r); end
      n_cmp++; if (dbz !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL bp_flags[%0d]: got dbz=%b ovf=%b want 0/0", i, dbz, ovf); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int e, a1, a2;
    send(4'b0101, 4'b1101, e, a1);
    n_cmp++; if (z !== 4'b1111 || r !== 4'b0010) begin n_err++; $display("FAIL b2b_5_m3: got z=%b r=%b want 1111/0010", z, r); end
    send(4'b1000, 4'b0111, e, a2);
    n_cmp++; if (z !== 4'b1111 || r !== 4'b1111) begin n_err++; $display("FAIL b2b_m8_7: got z=%b r=%b want 1111/1111", z, r); end
    n_cmp++; if (a2 - a1 !== N + 3) begin n_err++; $display("FAIL b2b_period: got %0d cycles want %0d", a2 - a1, N + 3); end
  endtask

  task automatic test_reset_mid();
    int e, a, w;
    logic seen;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    x = 4'b0111;
    y = 4'b0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_hs: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (z !== 4'b0000 || r !== 4'b0000) begin n_err++; $display("FAIL mid_rst_zr: got z=%b r=%b want 0000/0000", z, r); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_result: got out_valid seen=%b want 0", seen); end
    send(4'b0110, 4'b0010, e, a);
    n_cmp++; if (e !== 5) begin n_err++; $display("FAIL lat_6_2: got %0d edges want 5", e); end
    n_cmp++; if (z !== 4'b0011 || r !== 4'b0000) begin n_err++; $display("FAIL div_6_2: got z=%b r=%b want 0011/0000", z, r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_exact();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
